// File: rtl/pa_riscv.sv
// Shared RV32I definitions: opcodes, ALU operation codes, multi-cycle controller
// state encoding and datapath select encodings.
package pa_riscv;

    localparam logic [6:0] OP_LW      = 7'b0000011;
    localparam logic [6:0] OP_SW      = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    // ALU operations use the {funct7bit5, funct3} encoding of the R-type instructions
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECUTER,
        ST_ALUWB,
        ST_BEQ,
        ST_JAL
    } mcState_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } aluSrcA_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } aluSrcB_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10
    } resultSel_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluOpClass_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder shared by the single- and multi-cycle controllers:
// maps an operation class plus the instruction fields onto the ALU operation code.
module alu_decoder
    import pa_riscv::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [6:0]          i_operand,
    input  logic [2:0]          i_funct3,
    input  logic                i_funct7bit5,
    input  aluOpClass_t         i_aluOpClass,
    output logic [ALU_OP_W-1:0] o_aluLogicOperation
);

    always_comb begin
        o_aluLogicOperation = '0;
        case (i_aluOpClass)
            ALUOP_ADD:   o_aluLogicOperation[3:0] = ALU_ADD;
            ALUOP_SUB:   o_aluLogicOperation[3:0] = ALU_SUB;
            // funct7bit5 only selects SUB/SRA for register-register operations
            ALUOP_FUNCT: o_aluLogicOperation[3:0] = {(i_operand == OP_R_TYPE) & i_funct7bit5, i_funct3};
            default:     o_aluLogicOperation[3:0] = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller with memory wait handshake, watchdog and retire counter.
// Define MULTICYCLE_CONTROLLER_JAL_EN to add JAL support; otherwise JAL decodes as illegal.
module multicycle_controller
    import pa_riscv::*;
#(
    parameter int ALU_OP_W     = 4,
    parameter int WAIT_TIMEOUT = 15,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_operand,
    input  logic [2:0]              i_funct3,
    input  logic                    i_funct7bit5,
    input  logic                    i_zeroFlag,
    input  logic                    i_memReady,
    output logic                    o_pcWriteEn,
    output logic                    o_adrSel,
    output logic                    o_memReadEn,
    output logic                    o_memWriteEn,
    output logic                    o_irWriteEn,
    output logic                    o_regWriteEn,
    output logic [1:0]              o_aluSrcASel,
    output logic [1:0]              o_aluSrcBSel,
    output logic [1:0]              o_resultSel,
    output logic [ALU_OP_W-1:0]     o_aluLogicOperation,
    output logic                    o_illegal,
    output logic                    o_memTimeout,
    output logic [RETIRE_CNT_W-1:0] o_retireCount
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

    mcState_t                stateReg;
    mcState_t                stateNext;
    aluSrcA_t                aluSrcA;
    aluSrcB_t                aluSrcB;
    resultSel_t              resultSel;
    aluOpClass_t             aluOpClass;
    logic                    waitState;
    logic                    retire;
    logic [7:0]              waitCntReg;
    logic                    memTimeoutReg;
    logic [RETIRE_CNT_W-1:0] retireCountReg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stateReg       <= ST_FETCH;
            waitCntReg     <= '0;
            memTimeoutReg  <= 1'b0;
            retireCountReg <= '0;
        end else begin
            stateReg <= stateNext;
            // A not-ready cycle in a memory state always means the FSM stays put
            if (waitState && !i_memReady) begin
                if (waitCntReg != WAIT_LIMIT) begin
                    waitCntReg <= waitCntReg + 8'd1;
                end
                if (waitCntReg == WAIT_LIMIT - 8'd1) begin
                    memTimeoutReg <= 1'b1;
                end
            end else begin
                waitCntReg <= '0;
            end
            if (retire) begin
                retireCountReg <= retireCountReg + RETIRE_CNT_W'(1);
            end
        end
    end

    always_comb begin
        stateNext    = stateReg;
        o_pcWriteEn  = 1'b0;
        o_adrSel     = 1'b0;
        o_memReadEn  = 1'b0;
        o_memWriteEn = 1'b0;
        o_irWriteEn  = 1'b0;
        o_regWriteEn = 1'b0;
        o_illegal    = 1'b0;
        aluSrcA      = SRCA_PC;
        aluSrcB      = SRCB_RS2;
        resultSel    = RES_ALUOUT;
        aluOpClass   = ALUOP_ADD;
        waitState    = 1'b0;
        retire       = 1'b0;
        if (!i_rst) begin
            case (stateReg)
                ST_FETCH: begin
                    o_memReadEn = 1'b1;
                    aluSrcB     = SRCB_FOUR;
                    resultSel   = RES_ALU;
                    waitState   = 1'b1;
                    if (i_memReady) begin
                        o_irWriteEn = 1'b1;
                        o_pcWriteEn = 1'b1;
                        stateNext   = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    aluSrcA = SRCA_OLDPC;
                    aluSrcB = SRCB_IMM;
                    case (i_operand)
                        OP_LW, OP_SW: stateNext = ST_MEMADR;
                        OP_R_TYPE:    stateNext = ST_EXECUTER;
                        OP_B_TYPE:    stateNext = ST_BEQ;
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
                        OP_JAL:       stateNext = ST_JAL;
`endif
                        default: begin
                            o_illegal = 1'b1;
                            stateNext = ST_FETCH;
                        end
                    endcase
                end
                ST_MEMADR: begin
                    aluSrcA   = SRCA_RS1;
                    aluSrcB   = SRCB_IMM;
                    stateNext = (i_operand == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
                end
                ST_MEMREAD: begin
                    o_adrSel    = 1'b1;
                    o_memReadEn = 1'b1;
                    waitState   = 1'b1;
                    if (i_memReady) begin
                        stateNext = ST_MEMWB;
                    end
                end
                ST_MEMWB: begin
                    resultSel    = RES_DATA;
                    o_regWriteEn = 1'b1;
                    retire       = 1'b1;
                    stateNext    = ST_FETCH;
                end
                ST_MEMWRITE: begin
                    o_adrSel     = 1'b1;
                    o_memWriteEn = 1'b1;
                    waitState    = 1'b1;
                    if (i_memReady) begin
                        retire    = 1'b1;
                        stateNext = ST_FETCH;
                    end
                end
                ST_EXECUTER: begin
                    aluSrcA    = SRCA_RS1;
                    aluOpClass = ALUOP_FUNCT;
                    stateNext  = ST_ALUWB;
                end
                ST_ALUWB: begin
                    o_regWriteEn = 1'b1;
                    retire       = 1'b1;
                    stateNext    = ST_FETCH;
                end
                ST_BEQ: begin
                    aluSrcA     = SRCA_RS1;
                    aluOpClass  = ALUOP_SUB;
                    o_pcWriteEn = i_zeroFlag;
                    retire      = 1'b1;
                    stateNext   = ST_FETCH;
                end
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
                // ALUOut holds the jump target from DECODE; PC+4 goes to ALUOut for the link write
                ST_JAL: begin
                    aluSrcA     = SRCA_OLDPC;
                    aluSrcB     = SRCB_FOUR;
                    o_pcWriteEn = 1'b1;
                    stateNext   = ST_ALUWB;
                end
`endif
                default: stateNext = ST_FETCH;
            endcase
        end
    end

    alu_decoder #(
        .ALU_OP_W(ALU_OP_W)
    ) aluDecoder (
        .i_operand          (i_operand),
        .i_funct3           (i_funct3),
        .i_funct7bit5       (i_funct7bit5),
        .i_aluOpClass       (aluOpClass),
        .o_aluLogicOperation(o_aluLogicOperation)
    );

    assign o_aluSrcASel  = aluSrcA;
    assign o_aluSrcBSel  = aluSrcB;
    assign o_resultSel   = resultSel;
    assign o_memTimeout  = memTimeoutReg;
    assign o_retireCount = retireCountReg;

endmodule
